feature_col_fetch: RTL and testbench

Upstream feeder for the vertical window register stage. Reads feature-buffer words, each holding one column of KERNEL_SIZE rows for Tn channels, and issues KERNEL_SIZE consecutive columns per window on dia_0 or dia_1 with the enable/in_select timing that stage requires. It then waits for shift_done and hands the completed window to the PE array via valid/ready. It repeats for num_win windows, stepping col_stride columns each time.

---
 rtl/feature_col_fetch_pkg.sv | 45 ++++
 rtl/feature_col_fetch_col_addr_gen.sv | 77 +++++++
 rtl/feature_col_fetch.sv | 194 +++++++++++++++++++
 tb/tb_feature_col_fetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_col_fetch_pkg.sv
// -----------------------------------------------------------------------------
// feature_col_fetch_pkg
// Shared constants for the feature-column fetch slice: tensor geometry,
// feature-buffer address width, window counter width, FSM state encodings
// and the column address adder used by the fetch logic.
// -----------------------------------------------------------------------------
package feature_col_fetch_pkg;

    localparam int Tn              = 4;
    localparam int KERNEL_SIZE     = 5;
    localparam int FEATURE_WIDTH   = 16;
    localparam int FEAT_ADDR_WIDTH = 10;
    localparam int CNT_WIDTH       = 8;

    // One feature-buffer word: KERNEL_SIZE rows of one column for Tn channels.
    localparam int COL_WIDTH = Tn * KERNEL_SIZE * FEATURE_WIDTH;

    // Column index within a window burst.
    localparam int IDX_WIDTH = $clog2(KERNEL_SIZE);

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_WAIT_SHIFT = 3'd2;
    localparam logic [2:0] ST_HANDOFF    = 3'd3;
    localparam logic [2:0] ST_FIN        = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_ISSUE      = ST_ISSUE,
        S_WAIT_SHIFT = ST_WAIT_SHIFT,
        S_HANDOFF    = ST_HANDOFF,
        S_FIN        = ST_FIN
    } fetch_state_t;

    // Address plus a 4-bit step, step zero-extended, result wraps at the
    // top of the feature buffer.
    function automatic logic [FEAT_ADDR_WIDTH-1:0] col_addr_add(
        input logic [FEAT_ADDR_WIDTH-1:0] addr,
        input logic [3:0]                 step
    );
        return addr + {{(FEAT_ADDR_WIDTH-4){1'b0}}, step};
    endfunction

endpackage

// File: rtl/feature_col_fetch_col_addr_gen.sv
// -----------------------------------------------------------------------------
// col_addr_gen
// Column pointer and read-burst generator. Holds the window start pointer
// (col_ptr) and issues a KERNEL_SIZE-long read burst at col_ptr+j.
//   clk, rst     : clock, asynchronous active-high reset
//   load         : col_ptr <= base_addr (restart of a job)
//   step         : col_ptr <= col_ptr + col_stride (window advance)
//   launch       : start a burst from the updated pointer on the next cycle
//   base_addr    : job start address
//   col_stride   : column step between windows
//   rd_en/rd_addr: registered feature-buffer read strobe and address
//   last_col     : the current read is the final column of the burst
// -----------------------------------------------------------------------------
module col_addr_gen
    import feature_col_fetch_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       step,
    input  logic                       launch,
    input  logic [FEAT_ADDR_WIDTH-1:0] base_addr,
    input  logic [3:0]                 col_stride,
    output logic                       rd_en,
    output logic [FEAT_ADDR_WIDTH-1:0] rd_addr,
    output logic                       last_col
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(KERNEL_SIZE - 1);

    logic [FEAT_ADDR_WIDTH-1:0] col_ptr_r;
    logic [FEAT_ADDR_WIDTH-1:0] next_ptr_s;
    logic [FEAT_ADDR_WIDTH-1:0] rd_addr_r;
    logic [IDX_WIDTH-1:0]       col_idx_r;
    logic                       rd_en_r;

    // Next window start pointer: restart wins over a stride step.
    always_comb begin
        next_ptr_s = col_ptr_r;
        if (load) begin
            next_ptr_s = base_addr;
        end else if (step) begin
            next_ptr_s = col_addr_add(col_ptr_r, col_stride);
        end else begin
            next_ptr_s = col_ptr_r;
        end
    end

    // Pointer register and burst sequencer; a launch uses the pointer value
    // being written this edge so the first read needs no extra cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_ptr_r <= {FEAT_ADDR_WIDTH{1'b0}};
            rd_addr_r <= {FEAT_ADDR_WIDTH{1'b0}};
            col_idx_r <= {IDX_WIDTH{1'b0}};
            rd_en_r   <= 1'b0;
        end else begin
            col_ptr_r <= next_ptr_s;
            if (launch) begin
                rd_en_r   <= 1'b1;
                rd_addr_r <= next_ptr_s;
                col_idx_r <= {IDX_WIDTH{1'b0}};
            end else if (rd_en_r && (col_idx_r != LAST_IDX)) begin
                rd_addr_r <= col_addr_add(rd_addr_r, 4'd1);
                col_idx_r <= col_idx_r + IDX_WIDTH'(1);
            end else begin
                rd_en_r   <= 1'b0;
                col_idx_r <= {IDX_WIDTH{1'b0}};
            end
        end
    end

    assign rd_en    = rd_en_r;
    assign rd_addr  = rd_addr_r;
    assign last_col = rd_en_r && (col_idx_r == LAST_IDX);

endmodule

// File: rtl/feature_col_fetch.sv
// -----------------------------------------------------------------------------
// feature_col_fetch
// Feeds the vertical window register stage: for each of num_win windows it
// reads KERNEL_SIZE consecutive feature-buffer columns, forwards them on
// dia_0 or dia_1, pulses enable at the first column, waits for shift_done
// and then offers the window to the PE array with win_valid/win_ready.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : launch pulse (IDLE only)
//   bank_sel, base_addr,
//   col_stride, num_win   : job parameters, latched at start
//   rd_en, rd_addr, rd_data: feature-buffer read port (1-cycle latency)
//   dia_0, dia_1          : column data to the shift stage, per bank
//   enable, in_select,
//   shift_mod, shift_done : shift stage control/handshake
//   win_valid, win_ready  : window handoff to the PE array
//   busy, done            : job status
// -----------------------------------------------------------------------------
module feature_col_fetch
    import feature_col_fetch_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       bank_sel,
    input  logic [FEAT_ADDR_WIDTH-1:0] base_addr,
    input  logic [3:0]                 col_stride,
    input  logic [CNT_WIDTH-1:0]       num_win,
    output logic                       rd_en,
    output logic [FEAT_ADDR_WIDTH-1:0] rd_addr,
    input  logic [COL_WIDTH-1:0]       rd_data,
    output logic [COL_WIDTH-1:0]       dia_0,
    output logic [COL_WIDTH-1:0]       dia_1,
    output logic                       enable,
    output logic                       in_select,
    output logic                       shift_mod,
    input  logic                       shift_done,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       busy,
    output logic                       done
);

    fetch_state_t         state_r;
    logic                 bank_r;
    logic [3:0]           stride_r;
    logic [CNT_WIDTH-1:0] num_win_r;
    logic [CNT_WIDTH-1:0] win_cnt_r;
    logic                 enable_r;
    logic                 in_select_r;
    logic                 win_valid_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 rd_vld_r;
    logic [COL_WIDTH-1:0] dia_0_r;
    logic [COL_WIDTH-1:0] dia_1_r;

    logic start_acc_s;
    logic xfer_s;
    logic last_win_s;
    logic load_s;
    logic step_s;
    logic launch_s;
    logic rd_en_s;
    logic last_col_s;

    // Handshake decode feeding the address generator and the FSM.
    always_comb begin
        start_acc_s = (state_r == S_IDLE) && start;
        xfer_s      = (state_r == S_HANDOFF) && win_valid_r && win_ready;
        last_win_s  = ((win_cnt_r + CNT_WIDTH'(1)) == num_win_r);
        load_s      = start_acc_s;
        step_s      = xfer_s;
        launch_s    = (start_acc_s && (num_win != {CNT_WIDTH{1'b0}}))
                   || (xfer_s && !last_win_s);
    end

    col_addr_gen u_col_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .step       (step_s),
        .launch     (launch_s),
        .base_addr  (base_addr),
        .col_stride (stride_r),
        .rd_en      (rd_en_s),
        .rd_addr    (rd_addr),
        .last_col   (last_col_s)
    );

    // Window sequencing FSM with registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            bank_r      <= 1'b0;
            stride_r    <= 4'd0;
            num_win_r   <= {CNT_WIDTH{1'b0}};
            win_cnt_r   <= {CNT_WIDTH{1'b0}};
            enable_r    <= 1'b0;
            in_select_r <= 1'b0;
            win_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            enable_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        bank_r    <= bank_sel;
                        stride_r  <= col_stride;
                        num_win_r <= num_win;
                        win_cnt_r <= {CNT_WIDTH{1'b0}};
                        busy_r    <= 1'b1;
                        if (num_win == {CNT_WIDTH{1'b0}}) begin
                            state_r <= S_FIN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r     <= S_ISSUE;
                            enable_r    <= 1'b1;
                            in_select_r <= bank_sel;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last_col_s) begin
                        state_r <= S_WAIT_SHIFT;
                    end
                end
                S_WAIT_SHIFT: begin
                    if (shift_done) begin
                        state_r     <= S_HANDOFF;
                        win_valid_r <= 1'b1;
                    end
                end
                S_HANDOFF: begin
                    if (xfer_s) begin
                        win_valid_r <= 1'b0;
                        win_cnt_r   <= win_cnt_r + CNT_WIDTH'(1);
                        if (last_win_s) begin
                            state_r     <= S_FIN;
                            done_r      <= 1'b1;
                            in_select_r <= 1'b0;
                        end else begin
                            // Next window starts straight away, no bubble.
                            state_r  <= S_ISSUE;
                            enable_r <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                    win_valid_r <= 1'b0;
                    in_select_r <= 1'b0;
                end
            endcase
        end
    end

    // Column data path: read data arrives one cycle after rd_en and is
    // registered into the selected bank; the other bank keeps its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_r <= 1'b0;
            dia_0_r  <= {COL_WIDTH{1'b0}};
            dia_1_r  <= {COL_WIDTH{1'b0}};
        end else begin
            rd_vld_r <= rd_en_s;
            if (rd_vld_r) begin
                if (bank_r) begin
                    dia_1_r <= rd_data;
                end else begin
                    dia_0_r <= rd_data;
                end
            end
        end
    end

    assign rd_en     = rd_en_s;
    assign dia_0     = dia_0_r;
    assign dia_1     = dia_1_r;
    assign enable    = enable_r;
    assign in_select = in_select_r;
    assign shift_mod = 1'b0;
    assign win_valid = win_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_feature_col_fetch.sv
// -----------------------------------------------------------------------------
// tb_feature_col_fetch
// Self-checking bench: a table of jobs plus random jobs, each checked
// against a reference model of the read-address / column-data sequence and
// the window handshake timing, and a hand-written mid-job reset sequence.
// -----------------------------------------------------------------------------
module tb_feature_col_fetch;
    import feature_col_fetch_pkg::*;

    localparam int CW = COL_WIDTH;
    localparam int AW = FEAT_ADDR_WIDTH;
    localparam int K  = KERNEL_SIZE;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 bank_sel;
    logic [AW-1:0]        base_addr;
    logic [3:0]           col_stride;
    logic [CNT_WIDTH-1:0] num_win;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [CW-1:0]        rd_data;
    logic [CW-1:0]        dia_0;
    logic [CW-1:0]        dia_1;
    logic                 enable;
    logic                 in_select;
    logic                 shift_mod;
    logic                 shift_done;
    logic                 win_valid;
    logic                 win_ready;
    logic                 busy;
    logic                 done;

    feature_col_fetch dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel),
        .base_addr(base_addr), .col_stride(col_stride), .num_win(num_win),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .dia_0(dia_0), .dia_1(dia_1), .enable(enable), .in_select(in_select),
        .shift_mod(shift_mod), .shift_done(shift_done),
        .win_valid(win_valid), .win_ready(win_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]        base;
        logic [3:0]           stride;
        logic [CNT_WIDTH-1:0] nwin;
        logic                 bank;
        int                   hold;     // 0: win_ready tied high, else cycles held low
        bit                   spur;     // spurious shift_done during first ISSUE
        bit                   restart;  // start pulse while busy
        int                   exp_en;
        logic [AW-1:0]        exp_last;
    } vec_t;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
    } pend_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic [15:0]   salt = 16'h0000;
    logic [AW-1:0] exp_addr_q[$];
    pend_t         dia_q[$];
    logic [CW-1:0] bank_model[2];
    logic          cur_bank = 1'b0;
    bit            mon_on = 1'b0;
    int            en_count, rd_count, done_count;
    int            start_cyc = -10, start_due = -1, restart_due = -1;
    int            sd_due = -1, spur_due = -1, last_accept = -1;
    int            hold_cfg = 0, hold_ctr = 0;
    bit            prev_wait = 1'b0;
    logic [AW-1:0] last_rd;

    // Feature-buffer word for an address: address (xor salt) replicated.
    function automatic logic [CW-1:0] word_of(input logic [AW-1:0] a);
        logic [FEATURE_WIDTH-1:0] v;
        v = FEATURE_WIDTH'(a) ^ salt;
        return {(Tn*K){v}};
    endfunction

    // Feature-buffer model: one-cycle read latency, junk when not reading.
    always @(posedge clk) begin
        if (rd_en) rd_data <= word_of(rd_addr);
        else       rd_data <= {(CW/16){16'hDEAD}};
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    task automatic monitor();
        pend_t p;
        if (rd_en) begin
            rd_count++;
            last_rd = rd_addr;
            if (exp_addr_q.size() == 0) fail("unexpected_rd");
            else chk_i("rd_addr", int'(rd_addr), int'(exp_addr_q.pop_front()));
            dia_q.push_back('{cyc + 2, rd_addr});
        end
        if (dia_q.size() > 0 && dia_q[0].due == cyc) begin
            p = dia_q.pop_front();
            chk("dia_bank", cur_bank ? dia_1 : dia_0, word_of(p.a));
            bank_model[int'(cur_bank)] = word_of(p.a);
        end
        chk("dia_other", cur_bank ? dia_0 : dia_1, bank_model[int'(!cur_bank)]);
        if (enable) begin
            en_count++;
            if (last_accept < 0) chk_i("first_enable", cyc, start_cyc + 1);
            else                 chk_i("no_bubble", cyc, last_accept + 1);
            chk_i("enable_with_rd", int'(rd_en), 1);
            sd_due = cyc + K + 3;
            if (spur_due == -2) spur_due = cyc + 1;
        end
        if (rd_en || win_valid) chk_i("in_select", int'(in_select), int'(cur_bank));
        if (prev_wait) chk_i("valid_hold", int'(win_valid), 1);
        if (win_valid) chk_i("rd_idle_handoff", int'(rd_en), 0);
        if (cyc > start_cyc && done_count == 0) chk_i("busy", int'(busy), 1);
        chk_i("shift_mod", int'(shift_mod), 0);
        if (done) begin
            done_count++;
            chk_i("done_time", cyc, last_accept + 1);
        end
    endtask

    task automatic drive();
        shift_done = (cyc == sd_due) || (cyc == spur_due);
        start      = (cyc == start_due) || (cyc == restart_due);
        if (cyc == restart_due) begin
            base_addr  = 10'h2AA;
            bank_sel   = ~cur_bank;
            num_win    = 8'd0;
            col_stride = 4'd3;
        end
        if (hold_cfg == 0) begin
            win_ready = 1'b1;
        end else if (win_valid) begin
            hold_ctr++;
            win_ready = (hold_ctr > hold_cfg);
        end else begin
            hold_ctr  = 0;
            win_ready = 1'b0;
        end
        if (win_valid && win_ready) last_accept = cyc;
        prev_wait = win_valid && !win_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_on) monitor();
        drive();
    endtask

    task automatic setup_job(input vec_t v);
        exp_addr_q.delete();
        dia_q.delete();
        for (int w = 0; w < int'(v.nwin); w++)
            for (int j = 0; j < K; j++)
                exp_addr_q.push_back(AW'((int'(v.base) + w * int'(v.stride) + j) % (1 << AW)));
        cur_bank    = v.bank;
        base_addr   = v.base;
        col_stride  = v.stride;
        num_win     = v.nwin;
        bank_sel    = v.bank;
        hold_cfg    = v.hold;
        hold_ctr    = 0;
        en_count    = 0;
        rd_count    = 0;
        done_count  = 0;
        start_cyc   = cyc + 1;
        start_due   = start_cyc;
        restart_due = v.restart ? start_cyc + 4 : -1;
        spur_due    = v.spur ? -2 : -1;
        sd_due      = -1;
        last_accept = (v.nwin == 8'd0) ? start_cyc : -1;
        prev_wait   = 1'b0;
        mon_on      = 1'b1;
    endtask

    task automatic run_job(input vec_t v);
        int budget;
        int n;
        setup_job(v);
        budget = 40 + int'(v.nwin) * (K + 20 + v.hold);
        n = 0;
        while (done_count == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_count == 0) fail("timeout_done");
        tick();
        chk_i("busy_after_done", int'(busy), 0);
        tick();
        tick();
        chk_i("enable_count", en_count, v.exp_en);
        chk_i("read_count", rd_count, int'(v.nwin) * K);
        chk_i("addr_q_drained", exp_addr_q.size(), 0);
        chk_i("done_count", done_count, 1);
        if (rd_count > 0) chk_i("last_rd_addr", int'(last_rd), int'(v.exp_last));
    endtask

    task automatic check_all_zero(input string tag);
        chk_i({tag, "_rd_en"}, int'(rd_en), 0);
        chk_i({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_dia_0"}, dia_0, {CW{1'b0}});
        chk({tag, "_dia_1"}, dia_1, {CW{1'b0}});
        chk_i({tag, "_enable"}, int'(enable), 0);
        chk_i({tag, "_in_select"}, int'(in_select), 0);
        chk_i({tag, "_shift_mod"}, int'(shift_mod), 0);
        chk_i({tag, "_win_valid"}, int'(win_valid), 0);
        chk_i({tag, "_busy"}, int'(busy), 0);
        chk_i({tag, "_done"}, int'(done), 0);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        rst = 1'b1; start = 1'b0; bank_sel = 1'b0; base_addr = 10'h000;
        col_stride = 4'd1; num_win = 8'd0; shift_done = 1'b0; win_ready = 1'b0;
        bank_model[0] = {CW{1'b0}};
        bank_model[1] = {CW{1'b0}};

        //         base     stride nwin  bank  hold spur restart en  last
        vecs[0] = '{10'h010, 4'd1, 8'd1, 1'b0, 2,  1'b0, 1'b0, 1, 10'h014};
        vecs[1] = '{10'h010, 4'd2, 8'd3, 1'b1, 1,  1'b0, 1'b0, 3, 10'h018};
        vecs[2] = '{10'h020, 4'd1, 8'd3, 1'b0, 0,  1'b0, 1'b0, 3, 10'h026};
        vecs[3] = '{10'h040, 4'd3, 8'd2, 1'b1, 10, 1'b0, 1'b0, 2, 10'h047};
        vecs[4] = '{10'h3FE, 4'd1, 8'd1, 1'b0, 0,  1'b0, 1'b0, 1, 10'h002};
        vecs[5] = '{10'h155, 4'd1, 8'd0, 1'b1, 0,  1'b0, 1'b0, 0, 10'h000};
        vecs[6] = '{10'h100, 4'd5, 8'd2, 1'b0, 0,  1'b1, 1'b0, 2, 10'h109};
        vecs[7] = '{10'h080, 4'd1, 8'd1, 1'b1, 3,  1'b0, 1'b1, 1, 10'h084};

        // Reset state.
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // Reset during WAIT_SHIFT: everything clears, no done pulse follows.
        rv = '{10'h1C0, 4'd2, 8'd2, 1'b1, 0, 1'b0, 1'b0, 2, 10'h1C6};
        setup_job(rv);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        mon_on = 1'b0;
        sd_due = -1;
        start_due = -1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_i("midrst_no_done", int'(done), 0);
            chk_i("midrst_no_rd", int'(rd_en), 0);
        end
        rst = 1'b0;
        bank_model[0] = {CW{1'b0}};
        bank_model[1] = {CW{1'b0}};
        tick();
        run_job(vecs[2]);

        // Randomized jobs against the reference model.
        for (int i = 0; i < 6; i++) begin
            salt      = 16'($urandom);
            rv.base   = AW'($urandom);
            rv.stride = 4'($urandom_range(1, K));
            rv.nwin   = CNT_WIDTH'($urandom_range(1, 4));
            rv.bank   = 1'($urandom);
            rv.hold   = int'($urandom_range(0, 3));
            rv.spur   = 1'($urandom);
            rv.restart = 1'b0;
            rv.exp_en = int'(rv.nwin);
            rv.exp_last = AW'((int'(rv.base) + (int'(rv.nwin) - 1) * int'(rv.stride) + K - 1) % (1 << AW));
            run_job(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
